dmem_ahb_responder: RTL and testbench

//  AHB-Lite data-side responder for the 5-stage core. Sits at the far end of the bus

---
 rtl/dmem_ahb_responder_pkg.sv | 51 +++++
 rtl/dmem_ahb_responder_if.sv | 25 ++
 rtl/dmem_ahb_responder_sram_be.sv | 26 ++
 rtl/dmem_ahb_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_ahb_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ahb_responder_pkg.sv
// rtl/dmem_ahb_responder_pkg.sv - shared AHB-Lite data-bus encodings, FSM states and lane helpers
package dmem_ahb_responder_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } dmem_state_t;

    // Natural alignment check; sizes above a word are never legal on this bus.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~lo[0];
            HSIZE_WORD: return (lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

    // Byte-lane enables within the 32-bit word for a legal access.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lo;
            HSIZE_HALF: return 4'b0011 << lo;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Mask applied to right-justified load data so upper bytes read as zero.
    function automatic logic [31:0] size_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 32'h0000_00FF;
            HSIZE_HALF: return 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ahb_responder_if.sv
// rtl/dmem_ahb_responder_if.sv - AHB-Lite data-side bus bundle between core and responder
interface dmem_ahb_responder_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/dmem_ahb_responder_sram_be.sv
// rtl/dmem_ahb_responder_sram_be.sv - word RAM with per-byte write enables and registered read
module dmem_sram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbe,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; a read colliding with a write returns the pre-write word.
    always_ff @(posedge CLK) begin
        if (we && wbe[0]) mem[waddr][7:0]   <= wdata[7:0];
        if (we && wbe[1]) mem[waddr][15:8]  <= wdata[15:8];
        if (we && wbe[2]) mem[waddr][23:16] <= wdata[23:16];
        if (we && wbe[3]) mem[waddr][31:24] <= wdata[31:24];
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_ahb_responder.sv
// rtl/dmem_ahb_responder.sv - AHB-Lite data memory responder with wait states, error response and write bypass
module dmem_ahb_responder
    import dmem_ahb_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 CLK,
    input  logic                 RES,
    dmem_ahb_responder_if.slave  bus
);

    localparam int          ADDR_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] REGION_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_STATES - 1);

    dmem_state_t       state;
    logic [3:0]        wait_cnt;
    logic              hreadyout_q;
    logic              hresp_q;
    logic [31:0]       hrdata_q;

    // Data-phase slot: the transfer whose address phase was last accepted.
    logic [ADDR_W-1:0] dp_word;
    logic [1:0]        dp_lo;
    logic [2:0]        dp_size;
    logic              dp_write;

    // One-entry bypass of the write committed on the previous edge.
    logic              byp_valid;
    logic [ADDR_W-1:0] byp_word;
    logic [31:0]       byp_data;
    logic [3:0]        byp_be;

    logic              accept_slot;
    logic              valid;
    logic [31:0]       offset;
    logic              in_range;
    logic              req_ok;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wbe;
    logic [ADDR_W-1:0] ram_raddr;
    logic [31:0]       ram_rdata;
    logic [31:0]       ram_merged;
    logic              byp_hit;
    logic [31:0]       load_val;

    // A new address phase is only taken while no data phase is being stretched.
    assign accept_slot = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign valid       = bus.HSEL && bus.HREADY && (bus.HTRANS == HTRANS_NONSEQ) && accept_slot;
    assign offset      = bus.HADDR - BASE_ADDR;
    assign in_range    = (bus.HADDR >= BASE_ADDR) && (offset < REGION_BYTES);
    assign req_ok      = in_range && size_aligned(bus.HSIZE, bus.HADDR[1:0]);

    // Store data is taken from the final data-phase cycle, lane-shifted to its byte position.
    assign ram_we    = (state == ST_DATA) && dp_write;
    assign ram_wdata = bus.HWDATA << {dp_lo, 3'b000};
    assign ram_wbe   = byte_enables(dp_size, dp_lo);

    // Read the new address on accept, otherwise keep re-reading the pending word so
    // a stretched load picks up anything committed meanwhile.
    assign ram_raddr = valid ? offset[ADDR_W+1:2] : dp_word;

    dmem_sram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (dp_word),
        .wdata (ram_wdata),
        .wbe   (ram_wbe),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign byp_hit = byp_valid && (byp_word == dp_word);

    // Overlay bytes of a store that landed on the same edge the load's read was issued.
    always_comb begin
        ram_merged = ram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (byp_hit && byp_be[b]) ram_merged[8*b +: 8] = byp_data[8*b +: 8];
        end
    end

    assign load_val = (ram_merged >> {dp_lo, 3'b000}) & size_mask(dp_size);

    assign bus.HRDATA    = (state == ST_DATA && !dp_write) ? load_val : hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    // Transfer FSM, wait counter, data-phase slot, bypass entry and registered responses.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= 32'd0;
            dp_word     <= '0;
            dp_lo       <= 2'b00;
            dp_size     <= HSIZE_BYTE;
            dp_write    <= 1'b0;
            byp_valid   <= 1'b0;
            byp_word    <= '0;
            byp_data    <= 32'd0;
            byp_be      <= 4'b0000;
        end else begin
            byp_valid <= ram_we;
            if (ram_we) begin
                byp_word <= dp_word;
                byp_data <= ram_wdata;
                byp_be   <= ram_wbe;
            end

            if (state == ST_DATA && !dp_write) hrdata_q <= load_val;

            if (valid) begin
                dp_word  <= offset[ADDR_W+1:2];
                dp_lo    <= bus.HADDR[1:0];
                dp_size  <= bus.HSIZE;
                dp_write <= bus.HWRITE;
            end

            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (valid && !req_ok) begin
                        state       <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (valid && WAIT_STATES > 0) begin
                        state       <= ST_WAIT;
                        wait_cnt    <= WAIT_INIT;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else if (valid) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt    <= wait_cnt - 4'd1;
                        hreadyout_q <= 1'b0;
                    end
                    hresp_q <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ahb_responder.sv
// tb/tb_dmem_ahb_responder.sv - randomized bench for dmem_ahb_responder against a byte-addressed memory model
module tb_dmem_ahb_responder;
    import dmem_ahb_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 64;
    localparam int          NDUT  = 3;

    logic CLK = 1'b0;
    logic RES;
    always #5 CLK = ~CLK;

    logic        hsel_d   [NDUT];
    logic [31:0] haddr_d  [NDUT];
    logic [1:0]  htrans_d [NDUT];
    logic        hwrite_d [NDUT];
    logic [2:0]  hsize_d  [NDUT];
    logic [31:0] hwdata_d [NDUT];
    logic        rdy_o    [NDUT];
    logic        resp_o   [NDUT];
    logic [31:0] rdata_o  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        dmem_ahb_responder_if bus_if ();
        assign bus_if.HSEL   = hsel_d[g];
        assign bus_if.HADDR  = haddr_d[g];
        assign bus_if.HTRANS = htrans_d[g];
        assign bus_if.HWRITE = hwrite_d[g];
        assign bus_if.HSIZE  = hsize_d[g];
        assign bus_if.HWDATA = hwdata_d[g];
        assign bus_if.HREADY = bus_if.HREADYOUT;
        assign rdy_o[g]      = bus_if.HREADYOUT;
        assign resp_o[g]     = bus_if.HRESP;
        assign rdata_o[g]    = bus_if.HRDATA;
        dmem_ahb_responder #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES (WS)
        ) dut (
            .CLK (CLK),
            .RES (RES),
            .bus (bus_if)
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] data;
        int          gap;
    } txn_t;

    txn_t        txq [$];
    logic [7:0]  mem_m [NDUT][4*DEPTH];
    int          ai [NDUT];
    int          dpi [NDUT];
    int          wc [NDUT];
    int          hr1 [NDUT];
    int          gap_left [NDUT];
    bit          dpv [NDUT];
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic bit model_ok(input txn_t t);
        if (t.size > 3'd2) return 1'b0;
        if (t.addr < BASE || t.addr >= BASE + 32'(4*DEPTH)) return 1'b0;
        return (t.addr % (32'd1 << t.size)) == 32'd0;
    endfunction

    task automatic add(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] data);
        txn_t t;
        t.addr = addr; t.wr = wr; t.size = size; t.data = data; t.gap = 0;
        txq.push_back(t);
    endtask

    task automatic drive_idle(input int k);
        if ($urandom_range(0, 1) == 0) begin
            hsel_d[k] = 1'b0; htrans_d[k] = HTRANS_NONSEQ;
        end else begin
            hsel_d[k] = 1'b1; htrans_d[k] = HTRANS_IDLE;
        end
        haddr_d[k]  = BASE + 32'($urandom_range(0, 63));
        hwrite_d[k] = 1'($urandom_range(0, 1));
        hsize_d[k]  = 3'($urandom_range(0, 2));
    endtask

    task automatic drive_txn(input int k, input txn_t t);
        hsel_d[k] = 1'b1; htrans_d[k] = HTRANS_NONSEQ;
        haddr_d[k] = t.addr; hwrite_d[k] = t.wr; hsize_d[k] = t.size;
    endtask

    task automatic complete(input int k);
        txn_t        t;
        int          off;
        logic [31:0] e;
        t = txq[dpi[k]];
        if (model_ok(t)) begin
            off = int'(t.addr - BASE);
            expect_eq($sformatf("d%0d t%0d hresp", k, dpi[k]), 32'(resp_o[k]), 32'd0);
            expect_eq($sformatf("d%0d t%0d waits", k, dpi[k]), wc[k], ws_of(k));
            if (t.wr) begin
                for (int b = 0; b < (1 << t.size); b++) mem_m[k][off+b] = t.data[8*b +: 8];
            end else begin
                e = 32'd0;
                for (int b = 0; b < (1 << t.size); b++) e[8*b +: 8] = mem_m[k][off+b];
                expect_eq($sformatf("d%0d t%0d hrdata", k, dpi[k]), rdata_o[k], e);
            end
        end else begin
            expect_eq($sformatf("d%0d t%0d err hresp", k, dpi[k]), 32'(resp_o[k]), 32'd1);
            expect_eq($sformatf("d%0d t%0d err waits", k, dpi[k]), wc[k], 1);
            expect_eq($sformatf("d%0d t%0d err first", k, dpi[k]), hr1[k], 1);
        end
    endtask

    // One bus-master cycle, called just after the falling edge.
    task automatic step(input int k);
        logic r;
        r = rdy_o[k];
        if (dpv[k]) begin
            if (!r) begin
                wc[k]++;
                if (resp_o[k]) hr1[k]++;
                hwdata_d[k] = $urandom;
            end else begin
                complete(k);
                hwdata_d[k] = txq[dpi[k]].data;
            end
        end
        if (r) begin
            dpv[k] = 1'b0;
            if (ai[k] < txq.size() && gap_left[k] == 0) begin
                drive_txn(k, txq[ai[k]]);
                dpv[k] = 1'b1; dpi[k] = ai[k]; wc[k] = 0; hr1[k] = 0;
                ai[k]++;
                gap_left[k] = (ai[k] < txq.size()) ? txq[ai[k]].gap : 0;
            end else begin
                if (gap_left[k] > 0) gap_left[k]--;
                drive_idle(k);
            end
        end
    endtask

    initial begin
        bit          all_done;
        bit          got;
        logic [31:0] e;

        RES = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            drive_idle(k);
            hwdata_d[k] = 32'd0;
        end

        for (int w = 0; w < 16; w++) add(BASE + 32'(4*w), 1'b1, HSIZE_WORD, $urandom);
        add(BASE + 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        add(BASE + 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        add(BASE + 32'h20, 1'b1, HSIZE_WORD, 32'h0);
        add(BASE + 32'h21, 1'b1, HSIZE_BYTE, 32'hFFFF_FF5A);
        add(BASE + 32'h22, 1'b1, HSIZE_HALF, 32'hABCD_1234);
        add(BASE + 32'h20, 1'b0, HSIZE_WORD, 32'h0);
        add(BASE + 32'h23, 1'b0, HSIZE_BYTE, 32'h0);
        add(BASE + 32'h02, 1'b0, HSIZE_WORD, 32'h0);
        add(BASE + 32'h01, 1'b0, HSIZE_HALF, 32'h0);
        add(BASE + 32'h00, 1'b1, 3'd3, 32'h1357_9BDF);
        add(BASE + 32'(4*DEPTH), 1'b1, HSIZE_WORD, 32'h2468_ACE0);
        add(BASE + 32'h12, 1'b1, HSIZE_WORD, 32'h5555_AAAA);
        add(BASE + 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        add(BASE + 32'h00, 1'b0, HSIZE_WORD, 32'h0);

        for (int i = 0; i < 300; i++) begin
            txn_t t;
            int   sel;
            sel    = $urandom_range(0, 19);
            t.wr   = 1'($urandom_range(0, 1));
            t.data = $urandom;
            t.size = 3'($urandom_range(0, 2));
            t.gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            t.addr = BASE + 32'($urandom_range(0, 63));
            if (sel == 0) t.size = 3'($urandom_range(3, 7));
            else if (sel == 1) t.addr = BASE - 32'($urandom_range(1, 8));
            else if (sel == 2) t.addr = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 15));
            else if (sel < 8 && txq[$].wr) begin
                t.wr = 1'b0; t.size = HSIZE_WORD; t.addr = txq[$].addr & ~32'h3; t.gap = 0;
            end
            txq.push_back(t);
        end

        repeat (3) @(negedge CLK);
        for (int k = 0; k < NDUT; k++) begin
            expect_eq($sformatf("d%0d reset hreadyout", k), 32'(rdy_o[k]), 32'd1);
            expect_eq($sformatf("d%0d reset hresp", k), 32'(resp_o[k]), 32'd0);
            expect_eq($sformatf("d%0d reset hrdata", k), rdata_o[k], 32'd0);
            ai[k] = 0; dpv[k] = 1'b0; wc[k] = 0; hr1[k] = 0; dpi[k] = 0;
            gap_left[k] = txq[0].gap;
        end
        RES = 1'b0;

        all_done = 1'b0;
        for (int c = 0; c < 40000 && !all_done; c++) begin
            @(negedge CLK);
            all_done = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                step(k);
                if (ai[k] < txq.size() || dpv[k]) all_done = 1'b0;
            end
        end
        expect_eq("drain", 32'(all_done), 32'd1);

        // Reset during a wait state of a store on the three-wait-state instance.
        @(negedge CLK);
        hsel_d[2] = 1'b1; htrans_d[2] = HTRANS_NONSEQ; haddr_d[2] = BASE + 32'h14;
        hwrite_d[2] = 1'b1; hsize_d[2] = HSIZE_WORD; hwdata_d[2] = 32'h1111_1111;
        @(negedge CLK);
        expect_eq("rst store waiting", 32'(rdy_o[2]), 32'd0);
        drive_idle(2);
        hwdata_d[2] = 32'hCAFE_F00D;
        #2 RES = 1'b1;
        #1;
        expect_eq("rst async hreadyout", 32'(rdy_o[2]), 32'd1);
        expect_eq("rst async hresp", 32'(resp_o[2]), 32'd0);
        expect_eq("rst async hrdata", rdata_o[2], 32'd0);
        @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);
        hsel_d[2] = 1'b1; htrans_d[2] = HTRANS_NONSEQ; haddr_d[2] = BASE + 32'h14;
        hwrite_d[2] = 1'b0; hsize_d[2] = HSIZE_WORD;
        @(negedge CLK);
        drive_idle(2);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (rdy_o[2]) begin
                got = 1'b1;
                e = {mem_m[2][23], mem_m[2][22], mem_m[2][21], mem_m[2][20]};
                expect_eq("rst word kept", rdata_o[2], e);
            end else begin
                @(negedge CLK);
            end
        end
        expect_eq("rst load completes", 32'(got), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
